// File: rtl/cv32e40n_data_arbiter_if.sv
// OBI-style data port bundle (req/gnt/rvalid plus request and response fields).
// "master" is the side that issues requests; "slave" is the side that answers them.
interface cv32e40n_data_arbiter_if;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/cv32e40n_data_arbiter.sv
// Round-robin arbiter from the LSU (m1) and NVPE (m2) to one data memory (s1).
// It locks the selection while a request stalls and routes each response back through an ID FIFO.
module cv32e40n_data_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter bit M1_FIRST        = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   cv32e40n_data_arbiter_if.slave        m1,
   cv32e40n_data_arbiter_if.slave        m2,
   cv32e40n_data_arbiter_if.master       s1,
   output logic [2:0]                    outstanding_o,
   output logic                          err_o
);

   localparam logic       SEL_M1   = 1'b0;
   localparam logic       SEL_M2   = 1'b1;
   localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
   localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);

   logic       last_m_q, last_m_d;
   logic       hold_q, hold_d;
   logic       hold_m_q, hold_m_d;
   logic       err_q, err_d;
   logic [3:0] fifo_q, fifo_d;
   logic [1:0] head_q, head_d;
   logic [1:0] tail_q, tail_d;
   logic [2:0] count_q, count_d;

   logic sel, sel_req, full, req_s1, push, pop, head_id;

   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      return (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
   endfunction

   // A stalled request keeps its master until granted; otherwise alternate on contention.
   always_comb begin
      sel = SEL_M1;
      if (hold_q)                 sel = hold_m_q;
      else if (m1.req && m2.req)  sel = ~last_m_q;
      else if (m2.req)            sel = SEL_M2;
   end

   // Full uses the registered count, so a same-cycle response never frees a slot early.
   assign full    = (count_q >= MAX_CNT);
   assign sel_req = (sel == SEL_M2) ? m2.req : m1.req;
   assign req_s1  = sel_req & ~full & ~rst_i;
   assign push    = req_s1 & s1.gnt;
   assign head_id = fifo_q[head_q];
   assign pop     = s1.rvalid & (count_q != 3'd0) & ~rst_i;

   assign s1.req   = req_s1;
   assign s1.addr  = (sel == SEL_M2) ? m2.addr  : m1.addr;
   assign s1.we    = (sel == SEL_M2) ? m2.we    : m1.we;
   assign s1.be    = (sel == SEL_M2) ? m2.be    : m1.be;
   assign s1.wdata = (sel == SEL_M2) ? m2.wdata : m1.wdata;

   assign m1.gnt    = push & (sel == SEL_M1);
   assign m2.gnt    = push & (sel == SEL_M2);
   assign m1.rvalid = pop & (head_id == SEL_M1);
   assign m2.rvalid = pop & (head_id == SEL_M2);
   assign m1.rdata  = s1.rdata;
   assign m2.rdata  = s1.rdata;

   assign outstanding_o = count_q;
   assign err_o         = err_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      last_m_d = last_m_q;
      hold_d   = 1'b0;
      hold_m_d = hold_m_q;
      err_d    = err_q;
      fifo_d   = fifo_q;
      head_d   = head_q;
      tail_d   = tail_q;

      if (push) begin
         fifo_d[tail_q] = sel;
         tail_d         = ptr_inc(tail_q);
         last_m_d       = sel;
      end else if (req_s1) begin
         hold_d   = 1'b1;
         hold_m_d = sel;
      end

      if (pop) head_d = ptr_inc(head_q);
      if (s1.rvalid && count_q == 3'd0) err_d = 1'b1;

      count_d = count_q + {2'b00, push} - {2'b00, pop};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_m_q <= M1_FIRST ? SEL_M2 : SEL_M1;
         hold_q   <= 1'b0;
         hold_m_q <= SEL_M1;
         err_q    <= 1'b0;
         head_q   <= 2'd0;
         tail_q   <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         last_m_q <= last_m_d;
         hold_q   <= hold_d;
         hold_m_q <= hold_m_d;
         err_q    <= err_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
      end
   end

   // NOTE: FIFO payload is not reset; entries are only read while count_q marks them valid.
   always_ff @(posedge clk_i) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_cv32e40n_data_arbiter.sv
// Self-checking bench for cv32e40n_data_arbiter: vector table, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_cv32e40n_data_arbiter;
   localparam int MAX_OUT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] outstanding;
   logic       err;

   always #5 clk = ~clk;

   cv32e40n_data_arbiter_if m1 ();
   cv32e40n_data_arbiter_if m2 ();
   cv32e40n_data_arbiter_if s1 ();

   cv32e40n_data_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .M1_FIRST(1'b1)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .m1            (m1),
      .m2            (m2),
      .s1            (s1),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ordered list of issuing masters (1 or 2), last winner, locked master (0 = none).
   int mq[$];
   int m_last;
   int m_lock;
   bit m_err;

   task automatic model_reset();
      mq.delete();
      m_last = 2;
      m_lock = 0;
      m_err  = 1'b0;
   endtask

   function automatic int model_sel();
      if (m_lock != 0)          return m_lock;
      if (m1.req && m2.req)     return (m_last == 1) ? 2 : 1;
      if (m2.req)               return 2;
      return 1;
   endfunction

   function automatic bit model_issue();
      int s = model_sel();
      return ((s == 1) ? m1.req : m2.req) && (mq.size() < MAX_OUT);
   endfunction

   task automatic model_check();
      int s   = model_sel();
      bit iss = model_issue();
      bit rv1 = s1.rvalid && mq.size() > 0 && mq[0] == 1;
      bit rv2 = s1.rvalid && mq.size() > 0 && mq[0] == 2;
      check("m_req_s1", s1.req, iss);
      check("m_gnt_m1", m1.gnt, iss && s1.gnt && s == 1);
      check("m_gnt_m2", m2.gnt, iss && s1.gnt && s == 2);
      check("m_addr_s1", s1.addr, (s == 2) ? m2.addr : m1.addr);
      check("m_wdata_s1", s1.wdata, (s == 2) ? m2.wdata : m1.wdata);
      check("m_we_be_s1", {s1.we, s1.be}, (s == 2) ? {m2.we, m2.be} : {m1.we, m1.be});
      check("m_rvalid_m1", m1.rvalid, rv1);
      check("m_rvalid_m2", m2.rvalid, rv2);
      if (rv1) check("m_rdata_m1", m1.rdata, s1.rdata);
      if (rv2) check("m_rdata_m2", m2.rdata, s1.rdata);
      check("m_outstanding", outstanding, mq.size());
      check("m_err", err, m_err);
   endtask

   task automatic model_update();
      int s   = model_sel();
      bit iss = model_issue();
      if (s1.rvalid) begin
         if (mq.size() > 0) void'(mq.pop_front());
         else               m_err = 1'b1;
      end
      if (iss && s1.gnt) begin
         mq.push_back(s);
         m_last = s;
         m_lock = 0;
      end else if (iss) begin
         m_lock = s;
      end else begin
         m_lock = 0;
      end
   endtask

   task automatic set_inputs(input bit r1, input bit r2, input logic [31:0] a1, input logic [31:0] a2,
                             input bit g, input bit rv, input logic [31:0] rd);
      m1.req = r1; m1.addr = a1; m1.we = 1'b0; m1.be = 4'hF; m1.wdata = a1 ^ 32'h1111_0000;
      m2.req = r2; m2.addr = a2; m2.we = 1'b1; m2.be = 4'h3; m2.wdata = a2 ^ 32'h2222_0000;
      s1.gnt = g; s1.rvalid = rv; s1.rdata = rd;
   endtask

   // Apply inputs and sample at the falling edge; tick() then clocks the DUT and the model.
   task automatic drive(input bit r1, input bit r2, input logic [31:0] a1, input logic [31:0] a2,
                        input bit g, input bit rv, input logic [31:0] rd);
      set_inputs(r1, r2, a1, a2, g, rv, rd);
      @(negedge clk);
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_inputs(1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk);
      check("rst_req_s1", s1.req, 1'b0);
      check("rst_gnt_m1", m1.gnt, 1'b0);
      check("rst_gnt_m2", m2.gnt, 1'b0);
      check("rst_rvalid_m1", m1.rvalid, 1'b0);
      check("rst_rvalid_m2", m2.rvalid, 1'b0);
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit          r1, r2, g, rv;
      logic [31:0] rd;
      bit          g1, g2, v1, v2;
      logic [2:0]  out;
   } vec_t;

   vec_t tbl[5];

   initial begin
      // Contention after reset with a 1-cycle slave, then in-order responses.
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

      set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      model_reset();
      do_reset();

      drive(1'b0, 1'b0, 32'h0000_4444, 32'h0000_8888, 1'b0, 1'b0, 32'h0);
      check("reset_outstanding", outstanding, 3'd0);
      check("reset_err", err, 1'b0);
      check("idle_addr_follows_m1", s1.addr, 32'h0000_4444);
      tick();

      for (int i = 0; i < 5; i++) begin
         drive(tbl[i].r1, tbl[i].r2, 32'h0000_0100 + i, 32'h0000_0200 + i, tbl[i].g, tbl[i].rv, tbl[i].rd);
         check($sformatf("tbl%0d_gnt_m1", i), m1.gnt, tbl[i].g1);
         check($sformatf("tbl%0d_gnt_m2", i), m2.gnt, tbl[i].g2);
         check($sformatf("tbl%0d_rvalid_m1", i), m1.rvalid, tbl[i].v1);
         check($sformatf("tbl%0d_rvalid_m2", i), m2.rvalid, tbl[i].v2);
         check($sformatf("tbl%0d_outstanding", i), outstanding, tbl[i].out);
         if (tbl[i].v1) check($sformatf("tbl%0d_rdata_m1", i), m1.rdata, tbl[i].rd);
         if (tbl[i].v2) check($sformatf("tbl%0d_rdata_m2", i), m2.rdata, tbl[i].rd);
         tick();
      end

      // Stall hold: M2 locked at 0x1000 while M1 waits through a 3-cycle stall.
      do_reset();
      drive(1'b0, 1'b1, 32'h0000_2000, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
      check("stall_req_s1", s1.req, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h0000_2000, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
         check($sformatf("stall%0d_addr", i), s1.addr, 32'h0000_1000);
         check($sformatf("stall%0d_gnt_m1", i), m1.gnt, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 32'h0000_2000, 32'h0000_1000, 1'b1, 1'b0, 32'h0);
      check("stall_release_gnt_m2", m2.gnt, 1'b1);
      check("stall_release_gnt_m1", m1.gnt, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h0000_2000, 32'h0000_1000, 1'b1, 1'b0, 32'h0);
      check("stall_next_gnt_m1", m1.gnt, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0B0B);
      check("stall_resp_m2", m2.rvalid, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0C0C);
      check("stall_resp_m1", m1.rvalid, 1'b1);
      tick();

      // FIFO full: M1 streams, no responses for 4 cycles.
      do_reset();
      begin
         int grants = 0;
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0000_3000 + 4 * i, 32'h0, 1'b1, 1'b0, 32'h0);
            if (m1.gnt) grants++;
            if (i >= 2) check($sformatf("full%0d_req_s1", i), s1.req, 1'b0);
            tick();
         end
         check("full_grant_count", grants, 2);
         check("full_outstanding", outstanding, 3'd2);
      end
      drive(1'b1, 1'b0, 32'h0000_3010, 32'h0, 1'b1, 1'b1, 32'h0000_0001);
      check("full_pop_req_s1", s1.req, 1'b0);
      check("full_pop_rvalid_m1", m1.rvalid, 1'b1);
      tick();
      drive(1'b1, 1'b0, 32'h0000_3010, 32'h0, 1'b1, 1'b0, 32'h0);
      check("full_third_gnt", m1.gnt, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0010 + i);
         tick();
      end

      // Simultaneous push and pop with one transaction (from M2) outstanding.
      do_reset();
      drive(1'b0, 1'b1, 32'h0, 32'h0000_5000, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 32'h0000_6000, 32'h0, 1'b1, 1'b1, 32'h0000_00AA);
      check("pushpop_gnt_m1", m1.gnt, 1'b1);
      check("pushpop_rvalid_older", m2.rvalid, 1'b1);
      check("pushpop_rvalid_m1", m1.rvalid, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_00BB);
      check("pushpop_outstanding", outstanding, 3'd1);
      check("pushpop_second_resp", m1.rvalid, 1'b1);
      tick();

      // Spurious rvalid with an empty FIFO.
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0EEE);
      check("spur_rvalid_m1", m1.rvalid, 1'b0);
      check("spur_rvalid_m2", m2.rvalid, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
         check($sformatf("spur_err%0d", i), err, 1'b1);
         tick();
      end
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("spur_err_cleared", err, 1'b0);
      check("spur_outstanding_cleared", outstanding, 3'd0);
      tick();

      // Reset with two transactions in flight, then a late response.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 32'h0000_7000 + 4 * i, 32'h0, 1'b1, 1'b0, 32'h0);
         tick();
      end
      check("midflight_outstanding", outstanding, 3'd2);
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("midflight_after_rst_outstanding", outstanding, 3'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0777);
      check("late_rvalid_m1", m1.rvalid, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("late_rvalid_err", err, 1'b1);
      tick();

      // Random traffic against the model; the slave only answers when something is outstanding.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit r1 = ($urandom_range(0, 2) != 0);
         bit r2 = ($urandom_range(0, 2) != 0);
         bit g  = ($urandom_range(0, 3) != 0);
         bit rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
         drive(r1, r2, $urandom, $urandom, g, rv, $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
